// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-requester memory bus arbiter.
//   arb_state_t  : arbiter FSM states
//   grant_t      : identifies which requester owns the bus
//   ERR_READDATA : read data returned to a requester whose transfer timed out
//   WAIT_CNT_W   : width of the waitrequest stall counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } grant_t;

    localparam logic [31:0] ERR_READDATA = 32'hFFFF_FFFF;

    // Wide enough for the default TIMEOUT_CYCLES of 1024.
    localparam int unsigned WAIT_CNT_W = 11;

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker. Purely combinational.
// Ports:
//   req_instr  in   fetch port is requesting
//   req_data   in   data port is requesting
//   last_grant in   requester that completed the previous transfer
//   valid      out  at least one request is present
//   winner     out  requester to grant (meaningful only when valid)
// -----------------------------------------------------------------------------
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_instr,
    input  logic   req_data,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t winner
);

    always_comb begin
        valid  = req_instr | req_data;
        winner = GRANT_INSTR;
        if (req_instr && req_data) begin
            // On contention the port that was not served last wins.
            winner = (last_grant == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
        end else if (req_data) begin
            winner = GRANT_DATA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one waitrequest-style memory bus between the core's instruction-fetch
// port and data port. Transfers are serialised IDLE -> XFER -> RESP; payloads
// are latched at grant so the bus is driven only from registered state.
// A stall counter aborts a transfer whose waitrequest never drops.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   i_read, i_address                  fetch request and byte address
//   i_readdata, i_done                 fetched word and one-cycle done pulse
//   d_read, d_write, d_address,
//   d_byteenable, d_writedata          data request and payload
//   d_readdata, d_done                 data read result and done pulse
//   m_address, m_read, m_write,
//   m_byteenable, m_writedata          memory-side request
//   m_readdata, m_waitrequest          memory-side response / stall
//   err                                sticky error (timeout or read+write)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic        clk,
    input  logic        reset,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_done,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_done,

    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,

    output logic        err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t            state_q,      state_d;
    grant_t                grant_q,      grant_d;
    grant_t                last_grant_q, last_grant_d;
    logic [31:0]           addr_q,       addr_d;
    logic [3:0]            be_q,         be_d;
    logic [31:0]           wdata_q,      wdata_d;
    logic                  is_write_q,   is_write_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic [31:0]           i_rdata_q,    i_rdata_d;
    logic [31:0]           d_rdata_q,    d_rdata_d;
    logic                  err_q,        err_d;

    logic   pick_valid;
    grant_t pick_winner;

    rr_pick2 u_pick (
        .req_instr  (i_read),
        .req_data   (d_read | d_write),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        wait_cnt_d   = wait_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_winner;
                    wait_cnt_d = '0;
                    state_d    = XFER;
                    if (pick_winner == GRANT_INSTR) begin
                        addr_d     = i_address;
                        be_d       = 4'hF;
                        wdata_d    = '0;
                        is_write_d = 1'b0;
                    end else begin
                        addr_d     = d_address;
                        be_d       = d_byteenable;
                        wdata_d    = d_writedata;
                        // Conflicting read+write resolves as a write.
                        is_write_d = d_write;
                        if (d_read && d_write) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            XFER: begin
                if (!m_waitrequest) begin
                    if (!is_write_q) begin
                        if (grant_q == GRANT_INSTR) i_rdata_d = m_readdata;
                        else                        d_rdata_d = m_readdata;
                    end
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // This is the last tolerated stall cycle: abort.
                    err_d = 1'b1;
                    if (grant_q == GRANT_INSTR) i_rdata_d = ERR_READDATA;
                    else                        d_rdata_d = ERR_READDATA;
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end

            RESP: begin
                // Requests are deliberately not looked at here, so a port that
                // drops its request on done is never granted twice.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_INSTR;
            last_grant_q <= GRANT_DATA;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            wait_cnt_q   <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            wait_cnt_q   <= wait_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    // Outputs decode only registered state, so requester inputs never reach
    // the memory bus combinationally.
    assign m_address    = addr_q;
    assign m_byteenable = be_q;
    assign m_writedata  = wdata_q;
    assign m_read       = (state_q == XFER) && !is_write_q;
    assign m_write      = (state_q == XFER) &&  is_write_q;

    assign i_done       = (state_q == RESP) && (grant_q == GRANT_INSTR);
    assign d_done       = (state_q == RESP) && (grant_q == GRANT_DATA);
    assign i_readdata   = i_rdata_q;
    assign d_readdata   = d_rdata_q;
    assign err          = err_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares one single-port, waitrequest-style memory bus between the MIPS core's instruction-fetch port and its data port. Sits between the core and the unified memory model used in the test benches (instruction RAM mapped at 0xBFC00000 upward, data RAM below). It serialises transfers, arbitrates round-robin on contention, latches requester payloads and returns read data with a one-cycle done pulse. A timeout guards against a memory that never drops waitrequest.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1024: waitrequest-high cycles tolerated in one transfer before abort.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- i_read  in  1  instruction fetch request; held high until i_done.
- i_address  in  32  fetch byte address.
- i_readdata  out  32  fetched word; valid while i_done is high.
- i_done  out  1  one-cycle completion pulse for fetch.
- d_read  in  1  data read request; held until d_done.
- d_write  in  1  data write request; held until d_done.
- d_address  in  32  data byte address.
- d_byteenable  in  4  byte lanes for d_write/d_read.
- d_writedata  in  32  write payload.
- d_readdata  out  32  read result; valid while d_done is high.
- d_done  out  1  one-cycle completion pulse for data.
- m_address  out  32  memory address.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_byteenable  out  4  memory byte lanes; 4'b1111 for fetches.
- m_writedata  out  32  memory write payload.
- m_readdata  in  32  memory read data; valid when waitrequest is low.
- m_waitrequest  in  1  memory stall.
- err  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, XFER, RESP.
- IDLE, one requester active: grant it. Both active: grant the one not granted last (last_grant). Latch address, byteenable, writedata and direction at grant → XFER.
- A data request with d_read and d_write both high executes as a write; err is set.
- XFER: m_* driven from the latched copy. Requester inputs are ignored until done.
  - m_waitrequest low: capture m_readdata into the granted port's readdata register (reads only), update last_grant → RESP.
  - m_waitrequest high: increment wait counter. When the counter reaches TIMEOUT_CYCLES: drop strobes, set err, load readdata with 32'hFFFF_FFFF → RESP.
- RESP: assert the granted port's done for exactly one cycle. Requests are not sampled in this cycle, so a requester that drops its request on done is never regranted → IDLE.
- Write transfers leave d_readdata unchanged.
- Reset values:
  - state IDLE, last_grant = DATA (first contention goes to the fetch port).
  - All outputs 0, including i_readdata, d_readdata, m_address and err.
  - Wait counter 0.

## Timing
- Uncontended transfer, zero wait states:
  - request seen in cycle 0;
  - m_read or m_write high in cycle 1;
  - done high in cycle 2;
  - next grant decision in cycle 3.
- Peak throughput is one transfer per 3 cycles.
- Each waitrequest-high cycle adds one cycle.
- m_* outputs are decoded only from registered state/latches, so they are glitch-free with no combinational path from requester inputs.
- A request asserted during XFER or RESP waits until IDLE.
- Reset asserted mid-transfer: strobes are low from the cycle after the reset edge, no done pulse is issued, and the transfer is lost.
- Wait counter is 11 bits (wide enough for TIMEOUT_CYCLES) and cleared on entry to XFER.

## Structure
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, XFER, RESP};
  - typedef enum grant_t {GRANT_INSTR, GRANT_DATA};
  - constant ERR_READDATA = 32'hFFFF_FFFF.
- Sub-module rr_pick2: two-way round-robin picker. Inputs are the two requests and last_grant; outputs are a valid flag and the winner.
- Latches, the FSM and the timeout counter stay in mem_bus_arbiter.

## Test plan
- Reset, then i_read=1 with i_address=0xBFC00000 and a zero-wait memory returning 0x8C020000 → m_read high in cycle 1 with m_byteenable=4'hF; i_done high in cycle 2 with i_readdata=0x8C020000; err=0.
- i_read and d_write (0x00000400, 0xDEADBEEF, be=4'hF) asserted together and held → fetch completes first, then the write with m_writedata=0xDEADBEEF; next contention grants fetch again (strict alternation).
- d_read at 0x00000100, memory holds waitrequest high for 5 cycles then returns 0x11111111 → d_done exactly 7 cycles after m_read rises... correction: d_done rises 7 cycles after the request is seen, m_read stays high for 6 cycles, d_readdata=0x11111111.
- Memory waitrequest stuck high, TIMEOUT_CYCLES=16 → strobes drop after 16 stall cycles; done pulses with readdata=0xFFFFFFFF; err stays 1 until reset.
- Reset asserted in the second cycle of a stalled d_write → m_write=0 the next cycle, no d_done, all outputs 0; the first post-reset contention grants fetch.
- d_read and d_write both high → treated as write; err=1; d_readdata unchanged.
